// File: rtl/fsm_job_arbiter_pkg.sv
// Shared definitions for the job arbiter: FSM state encodings, default
// parameter values and the round-robin search helper.
//   DEF_N / DEF_DW / DEF_TIMEOUT : default requester count, payload width
//                                  and watchdog limit in WAIT cycles
//   S_*                          : 3-bit FSM state encodings
//   next_rr(req, ptr, n)         : index of the first set req bit at or
//                                  after ptr, wrapping n-1 -> 0
package fsm_job_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_FEED   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // req is zero-extended to 8 bits so one function serves every N in 2..8.
    // With no bit set, ptr is returned; callers qualify the result with |req.
    function automatic int unsigned next_rr(input logic [7:0]  req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned sel;
        int unsigned j;
        bit          found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            j = (ptr + k) % n;
            if (!found && (k < n) && req[j]) begin
                sel   = j;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fsm_job_arbiter_if.sv
// Bundle of the requester-side and engine-side handshakes of the job arbiter.
//   slave  : arbiter view (takes requests and engine status, drives grants,
//            responses and engine controls)
//   master : requester/engine view (the opposite directions)
// Signals:
//   req, req_valid, req_data        requester job requests and packed payloads
//   grant, rsp_valid, rsp_err,
//   rsp_data, busy                  arbiter status and responses
//   eng_ready, eng_done,
//   eng_data_out                    engine status and result
//   eng_start, eng_data_valid,
//   eng_data_in                     engine launch handshake and payload
interface fsm_job_arbiter_if
    import fsm_job_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
);
    logic [N-1:0]    req;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    logic            eng_ready;
    logic            eng_done;
    logic [DW-1:0]   eng_data_out;
    logic            eng_start;
    logic            eng_data_valid;
    logic [DW-1:0]   eng_data_in;

    modport slave (
        input  req, req_valid, req_data, eng_ready, eng_done, eng_data_out,
        output grant, rsp_valid, rsp_err, rsp_data, busy,
               eng_start, eng_data_valid, eng_data_in
    );

    modport master (
        output req, req_valid, req_data, eng_ready, eng_done, eng_data_out,
        input  grant, rsp_valid, rsp_err, rsp_data, busy,
               eng_start, eng_data_valid, eng_data_in
    );

endinterface

// File: rtl/fsm_job_arbiter_rr_pick.sv
// Combinational N-way round-robin picker.
//   i_req    : request vector
//   i_rr_ptr : highest-priority index for this pick
//   o_pick   : one-hot of the chosen requester, all zero when no request
//   o_idx    : binary index of the chosen requester
module fsm_job_arbiter_rr_pick
    import fsm_job_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_pick,
    output logic [IW-1:0] o_idx
);

    logic [7:0]  w_req_ext;
    int unsigned w_sel;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = i_req;
    end

    assign w_sel  = next_rr(w_req_ext, int'(i_rr_ptr), N);
    assign o_idx  = IW'(w_sel);
    assign o_pick = (|i_req) ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/fsm_job_arbiter.sv
// Shares one single-job engine among N requesters, round-robin, with a
// watchdog that fails a job that hangs or is silently aborted by the engine.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   if_bus : slave view of fsm_job_arbiter_if (requests/responses/engine)
//
// state  | meaning
// IDLE   | wait for any request while the engine is ready
// GRANT  | owner index held; latch owner payload and valid
// LAUNCH | one-cycle engine start pulse
// FEED   | present payload to engine, clear watchdog
// WAIT   | wait for done; watchdog or ready-rise abort -> ERR
// RESP   | pulse owner rsp_valid with captured result, advance pointer
// ERR    | pulse owner rsp_valid with rsp_err, advance pointer
module fsm_job_arbiter
    import fsm_job_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    fsm_job_arbiter_if.slave  if_bus
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_rr_ptr;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic [DW-1:0] r_result;
    logic [CW-1:0] r_cnt;
    logic          r_ready_q;

    logic [N-1:0]  w_pick;
    logic [IW-1:0] w_pick_idx;
    logic [N-1:0]  w_owner;
    logic [IW-1:0] w_ptr_next;
    logic          w_abort;

    fsm_job_arbiter_rr_pick #(.N(N), .IW(IW)) u_rr_pick (
        .i_req    (if_bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick),
        .o_idx    (w_pick_idx)
    );

    assign w_owner    = N'(1) << r_idx;
    assign w_ptr_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    // The engine raising ready without a done means it dropped the job.
    assign w_abort    = if_bus.eng_ready && !r_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rr_ptr  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_ready_q <= 1'b0;
        end else begin
            r_ready_q <= if_bus.eng_ready;
            case (r_state)
                S_IDLE: begin
                    // Index is captured on entry so grant is clean from the
                    // first GRANT cycle; later req edges do not move it.
                    if (|w_pick && if_bus.eng_ready) begin
                        r_idx   <= w_pick_idx;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_data  <= if_bus.req_data[int'(r_idx)*DW +: DW];
                    r_valid <= if_bus.req_valid[r_idx];
                    r_state <= S_LAUNCH;
                end
                S_LAUNCH: r_state <= S_FEED;
                S_FEED: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (if_bus.eng_done) begin
                        r_result <= if_bus.eng_data_out;
                        r_state  <= S_RESP;
                    end else if ((r_cnt == TO_LAST) || w_abort) begin
                        r_state <= S_ERR;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP, S_ERR: begin
                    r_rr_ptr <= w_ptr_next;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_bus.busy           = (r_state != S_IDLE);
    assign if_bus.grant          = (r_state != S_IDLE) ? w_owner : '0;
    assign if_bus.eng_start      = (r_state == S_LAUNCH);
    assign if_bus.eng_data_valid = (r_state == S_FEED) && r_valid;
    assign if_bus.eng_data_in    = (r_state == S_FEED) ? r_data : '0;
    assign if_bus.rsp_valid      = ((r_state == S_RESP) || (r_state == S_ERR)) ? w_owner : '0;
    assign if_bus.rsp_err        = (r_state == S_ERR);
    assign if_bus.rsp_data       = (r_state == S_RESP) ? r_result : '0;

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Directed bench for fsm_job_arbiter: the engine is scripted step by step and
// every output is compared against hand-computed values.
module tb_fsm_job_arbiter;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] pay [N] = '{8'h3C, 8'h51, 8'h62, 8'h73};

    always #5 clk = ~clk;

    fsm_job_arbiter_if #(.N(N), .DW(DW)) bus ();

    fsm_job_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .if_bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.eng_done     = 1'b0;
        bus.eng_data_out = '0;
        bus.eng_ready    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Starts in IDLE with req set. mode 0: done in WAIT cycle d with res;
    // mode 1: never done (watchdog); mode 2: ready rises in WAIT cycle d.
    // stray: a done pulse is driven during LAUNCH and must be ignored.
    task automatic run_job(input string tag, input int idx, input int mode, input int d,
                           input logic [DW-1:0] res, input logic vld, input bit stray);
        logic [31:0] own;
        own = 32'(1) << idx;
        tick();
        chk({tag, " grant"}, bus.grant, own);
        chk({tag, " start_early"}, bus.eng_start, 0);
        chk({tag, " busy"}, bus.busy, 1);
        tick();
        chk({tag, " start"}, bus.eng_start, 1);
        chk({tag, " grant_launch"}, bus.grant, own);
        bus.eng_ready = 1'b0;
        if (stray) begin
            bus.eng_done     = 1'b1;
            bus.eng_data_out = 8'hEE;
        end
        tick();
        bus.eng_done     = 1'b0;
        bus.eng_data_out = '0;
        chk({tag, " start_pulse"}, bus.eng_start, 0);
        chk({tag, " data_valid"}, bus.eng_data_valid, vld);
        chk({tag, " data_in"}, bus.eng_data_in, pay[idx]);
        tick();
        if (mode == 1) begin
            repeat (TIMEOUT - 1) tick();
            chk({tag, " wait_last"}, bus.rsp_valid, 0);
            chk({tag, " busy_last"}, bus.busy, 1);
            tick();
            bus.eng_ready = 1'b1;
        end else begin
            repeat (d - 1) tick();
            chk({tag, " wait_hold"}, bus.rsp_valid, 0);
            bus.eng_ready = 1'b1;
            if (mode == 0) begin
                bus.eng_done     = 1'b1;
                bus.eng_data_out = res;
            end
            tick();
            bus.eng_done     = 1'b0;
            bus.eng_data_out = '0;
        end
        chk({tag, " rsp_valid"}, bus.rsp_valid, own);
        chk({tag, " rsp_err"}, bus.rsp_err, (mode == 0) ? 0 : 1);
        chk({tag, " rsp_data"}, bus.rsp_data, (mode == 0) ? res : 0);
        chk({tag, " grant_rsp"}, bus.grant, own);
        tick();
        chk({tag, " rsp_pulse"}, bus.rsp_valid, 0);
        chk({tag, " idle"}, bus.busy, 0);
        chk({tag, " grant_clr"}, bus.grant, 0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req          = '0;
        bus.req_valid    = '1;
        bus.req_data     = {pay[3], pay[2], pay[1], pay[0]};
        bus.eng_ready    = 1'b1;
        bus.eng_done     = 1'b0;
        bus.eng_data_out = '0;
        tick();
        chk("rst busy", bus.busy, 0);
        chk("rst grant", bus.grant, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_data", bus.rsp_data, 0);
        chk("rst start", bus.eng_start, 0);
        chk("rst data_valid", bus.eng_data_valid, 0);
        chk("rst data_in", bus.eng_data_in, 0);
        tick();
        reset = 1'b0;

        // Engine not ready: request must wait in IDLE.
        bus.eng_ready = 1'b0;
        bus.req       = 4'b0001;
        tick();
        tick();
        chk("noready busy", bus.busy, 0);
        chk("noready grant", bus.grant, 0);
        bus.eng_ready = 1'b1;

        run_job("t1", 0, 0, 3, 8'hAA, 1'b1, 1'b0);
        run_job("t1_sole", 0, 0, 1, 8'h11, 1'b1, 1'b0);

        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++)
            run_job($sformatf("t2_all%0d", i), i, 0, 2, 8'hA0 + 8'(i), 1'b1, 1'b0);
        bus.req = 4'b1010;
        run_job("t2_odd1", 1, 0, 2, 8'hB1, 1'b1, 1'b0);
        run_job("t2_odd3", 3, 0, 2, 8'hB3, 1'b1, 1'b0);

        do_reset();
        bus.req = 4'b0011;
        run_job("t3_to", 0, 1, 0, 8'h00, 1'b1, 1'b0);
        run_job("t3_next", 1, 0, 2, 8'h5A, 1'b1, 1'b0);

        do_reset();
        bus.req       = 4'b0001;
        bus.req_valid = 4'b1110;
        run_job("t4_abort", 0, 2, 2, 8'h00, 1'b0, 1'b0);
        bus.req_valid = 4'b1111;

        do_reset();
        run_job("t5_edge", 0, 0, TIMEOUT, 8'hC3, 1'b1, 1'b1);

        // Move the pointer to 1, then reset mid-job; the pointer must restart at 0.
        do_reset();
        run_job("t6_pre", 0, 0, 1, 8'h22, 1'b1, 1'b0);
        bus.req = 4'b0101;
        tick();
        chk("t6 grant2", bus.grant, 4'b0100);
        tick();
        bus.eng_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("t6 in_wait", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("t6 rst_grant", bus.grant, 0);
        chk("t6 rst_busy", bus.busy, 0);
        chk("t6 rst_rsp", bus.rsp_valid, 0);
        tick();
        chk("t6 rst_rsp_hold", bus.rsp_valid, 0);
        reset         = 1'b0;
        bus.eng_ready = 1'b1;
        tick();
        chk("t6 ptr_restart", bus.grant, 4'b0001);
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("t6 grant_req2", bus.grant, 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
